// File: rtl/branch_pred_unit_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Combinational definitions only; no timing or flow-control behaviour.
package branch_pred_unit_pkg;

  localparam int BP_XLEN        = 32;
  localparam int BP_BTB_ENTRIES = 64;
  localparam int BP_INDEX_BITS  = $clog2(BP_BTB_ENTRIES);
  localparam int BP_TAG_BITS    = BP_XLEN - BP_INDEX_BITS - 2;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_XLEN-1:0]     target;
    logic [1:0]             ctr;
    logic                   is_br;
  } btb_entry_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating direction counter next-value function, shared with future BHTs.
// Purely combinational, zero latency, no flow control.
module sat_ctr2
  import branch_pred_unit_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB with 2-bit counters: same-cycle lookup, updates land on the next edge.
// No backpressure; updates arriving while not ready or alongside a flush are dropped.
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int XLEN        = BP_XLEN,
  parameter int BTB_ENTRIES = BP_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_en,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_is_branch,
  input  logic            flush_all,
  output logic            ready
);

  localparam int INDEX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_BITS   = XLEN - INDEX_BITS - 2;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(BTB_ENTRIES - 1);

  bp_state_e             state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_idx_q, sweep_idx_d;
  logic                  sweep_clr;

  // Entry storage; only valid_q is touched by the sweep, the rest stays SRAM-friendly.
  logic                valid_q  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]     target_q [BTB_ENTRIES];
  logic [1:0]          ctr_q    [BTB_ENTRIES];
  logic                is_br_q  [BTB_ENTRIES];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= BP_INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      BP_INIT: begin
        if (flush_all) begin
          sweep_idx_d = '0;
        end else if (sweep_idx_q == LAST_IDX) begin
          state_d     = BP_RUN;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + INDEX_BITS'(1);
        end
      end
      BP_RUN: begin
        if (flush_all) begin
          state_d     = BP_INIT;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d     = BP_INIT;
        sweep_idx_d = '0;
      end
    endcase
  end

  always_comb begin
    ready     = (state_q == BP_RUN);
    sweep_clr = (state_q == BP_INIT);
  end

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [XLEN-1:0]       lk_seq_pc;

  assign lk_idx    = if_pc[INDEX_BITS+1:2];
  assign lk_tag    = if_pc[XLEN-1:INDEX_BITS+2];
  assign lk_seq_pc = if_pc + XLEN'(4);

  always_comb begin
    pred_hit    = ready && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && (!is_br_q[lk_idx] || ctr_q[lk_idx][1]);
    pred_target = pred_taken ? target_q[lk_idx] : lk_seq_pc;
  end

  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  up_fire;
  logic                  up_hit;
  logic                  up_alloc;
  logic                  up_we;
  logic [1:0]            ctr_trained;
  logic [1:0]            ctr_wr;
  logic                  up_pc_lsb_unused;

  assign up_idx           = update_pc[INDEX_BITS+1:2];
  assign up_tag           = update_pc[XLEN-1:INDEX_BITS+2];
  assign up_pc_lsb_unused = ^update_pc[1:0];

  sat_ctr2 u_sat_ctr2 (
    .ctr      (ctr_q[up_idx]),
    .taken    (update_taken),
    .ctr_next (ctr_trained)
  );

  // Not-taken misses leave the table alone so cold fall-through code cannot evict entries.
  always_comb begin
    up_fire  = update_en && ready && !flush_all;
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_alloc = up_fire && !up_hit && update_taken;
    up_we    = up_fire && (up_hit || update_taken);
    if (up_alloc)             ctr_wr = CTR_WT;
    else if (update_is_branch) ctr_wr = ctr_trained;
    else                      ctr_wr = ctr_q[up_idx];
  end

  always_ff @(posedge clk) begin
    if (sweep_clr) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (up_we) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (up_we) begin
      ctr_q[up_idx]   <= ctr_wr;
      is_br_q[up_idx] <= update_is_branch;
      if (update_taken) target_q[up_idx] <= update_target;
      if (up_alloc)     tag_q[up_idx]    <= up_tag;
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed plus randomized checks of branch_pred_unit against a table-level BTB model.
module tb_branch_pred_unit;

  localparam int N_ENT = 64;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_is_branch;
  logic        flush_all;
  logic        ready;

  branch_pred_unit dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .update_en        (update_en),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_is_branch (update_is_branch),
    .flush_all        (flush_all),
    .ready            (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a table keyed by (pc/4) mod N, plus cycles left until ready.
  bit          m_valid [N_ENT];
  int unsigned m_tag   [N_ENT];
  int unsigned m_tgt   [N_ENT];
  int          m_ctr   [N_ENT];
  bit          m_br    [N_ENT];
  int          m_wait  = N_ENT;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < N_ENT; i++) m_valid[i] = 1'b0;
    m_wait = N_ENT;
  endtask

  task automatic model_train(input int unsigned pc, input bit tk, input int unsigned tgt, input bit br);
    int unsigned idx;
    int unsigned tg;
    idx = (pc / 4) % N_ENT;
    tg  = pc / (4 * N_ENT);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      if (br) m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                              : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
      if (tk) m_tgt[idx] = tgt;
      m_br[idx] = br;
    end else if (tk) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_tgt[idx]   = tgt;
      m_br[idx]    = br;
      m_ctr[idx]   = 2;
    end
  endtask

  // One clock: drive after negedge, compare mid-cycle, advance the model at posedge.
  task automatic step(input bit rst_n, input bit u_en, input int unsigned u_pc, input bit u_tk,
                      input int unsigned u_tgt, input bit u_br, input bit fl, input int unsigned pc);
    int unsigned idx;
    bit          e_rdy, e_hit, e_tk;
    int unsigned e_tgt;
    @(negedge clk);
    reset            = rst_n;
    update_en        = u_en;
    update_pc        = u_pc;
    update_taken     = u_tk;
    update_target    = u_tgt;
    update_is_branch = u_br;
    flush_all        = fl;
    if_pc            = pc;
    #1;
    idx   = (pc / 4) % N_ENT;
    e_rdy = (m_wait == 0);
    e_hit = e_rdy && m_valid[idx] && (m_tag[idx] == pc / (4 * N_ENT));
    e_tk  = e_hit && (!m_br[idx] || m_ctr[idx] >= 2);
    e_tgt = e_tk ? m_tgt[idx] : pc + 4;
    check("ready", {31'd0, ready}, {31'd0, e_rdy});
    check("pred_hit", {31'd0, pred_hit}, {31'd0, e_hit});
    check("pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
    check("pred_target", pred_target, e_tgt);
    @(posedge clk);
    if (!rst_n) begin
      model_invalidate();
    end else begin
      if (u_en && m_wait == 0 && !fl) model_train(u_pc, u_tk, u_tgt, u_br);
      if (fl) model_invalidate();
      else if (m_wait > 0) m_wait--;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input int unsigned pc);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, pc);
  endtask

  task automatic upd(input int unsigned u_pc, input bit tk, input int unsigned tgt, input bit br,
                     input int unsigned pc);
    step(1, 1, u_pc, tk, tgt, br, 0, pc);
  endtask

  initial begin
    reset = 1'b0; update_en = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; update_is_branch = 1'b0; flush_all = 1'b0; if_pc = 32'h100;

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h100);
    cyc = 0;
    // Sweep after reset, with an update mid-sweep that must be dropped.
    idle(10, 32'h100);
    upd(32'h100, 1, 32'h999, 1, 32'h100);
    idle(54, 32'h100);
    check("ready_at_64", {31'd0, ready}, 32'd1);
    // Allocation; same-cycle lookup returns the old (miss) contents.
    upd(32'h100, 1, 32'h80, 1, 32'h100);
    idle(1, 32'h100);
    check("alloc_target", pred_target, 32'h80);
    // Training down to strongly not-taken, then saturating up.
    upd(32'h100, 0, 0, 1, 32'h100);
    upd(32'h100, 0, 0, 1, 32'h100);
    idle(1, 32'h100);
    check("snt_target", pred_target, 32'h104);
    for (int i = 0; i < 4; i++) upd(32'h100, 1, 32'h80, 1, 32'h100);
    upd(32'h100, 0, 0, 1, 32'h100);
    idle(1, 32'h100);
    check("st_after_one_nt", {31'd0, pred_taken}, 32'd1);
    // Aliasing at index 0.
    idle(1, 32'h200);
    upd(32'h200, 1, 32'h300, 1, 32'h200);
    idle(1, 32'h100);
    idle(1, 32'h200);
    // Jump entries ignore direction training.
    upd(32'h40, 1, 32'h400, 0, 32'h40);
    upd(32'h40, 0, 0, 0, 32'h40);
    idle(1, 32'h40);
    check("jump_target", pred_target, 32'h400);
    // Flush with a coincident update, then an update mid-sweep.
    step(1, 1, 32'h80, 1, 32'h1000, 1, 1, 32'h40);
    idle(20, 32'h40);
    upd(32'h80, 1, 32'h1000, 1, 32'h80);
    idle(43, 32'h200);
    idle(1, 32'h40);
    idle(1, 32'h80);
    idle(1, 32'h200);
    // Flush in the middle of a sweep restarts it.
    upd(32'h100, 1, 32'h80, 1, 32'h100);
    step(1, 0, 0, 0, 0, 0, 1, 32'h100);
    idle(30, 32'h100);
    step(1, 0, 0, 0, 0, 0, 1, 32'h100);
    idle(N_ENT + 2, 32'h100);

    // Randomized phase over a small PC pool to force aliasing and retraining.
    for (int i = 0; i < 3000; i++) begin
      int unsigned u_pc, l_pc, u_tgt;
      bit rst_n, fl, en;
      u_pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 5) << 2);
      l_pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 5) << 2);
      u_tgt = $urandom & 32'hffff_fffc;
      rst_n = ($urandom_range(0, 999) != 0);
      fl    = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 1) == 1);
      step(rst_n, en, u_pc, $urandom_range(0, 1) == 1, u_tgt, $urandom_range(0, 3) != 0, fl, l_pc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
Fetch-side branch prediction unit. It holds a direct-mapped BTB with per-entry 2-bit saturating direction counters and returns a same-cycle prediction for the IF PC. It consumes the resolved-branch update stream driven by the EX stage (bp_update_*/btb_* signals) and trains on it. A post-reset and flush sweep FSM invalidates every entry before predictions are enabled.

Parameters:
XLEN, 32, datapath width (riscv_pkg value)
BTB_ENTRIES, 64, number of entries; power of two, at least 2
INDEX_BITS, $clog2(BTB_ENTRIES), localparam; tag width is XLEN-INDEX_BITS-2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
if_pc  in  XLEN  fetch PC to predict
pred_hit  out  1  BTB tag hit for if_pc
pred_taken  out  1  predicted taken
pred_target  out  XLEN  predicted next PC
update_en  in  1  resolved branch/jump from EX (bp_update_en)
update_pc  in  XLEN  PC of resolved instruction
update_taken  in  1  actual direction
update_target  in  XLEN  actual target
update_is_branch  in  1  1 = conditional branch, 0 = jump
flush_all  in  1  invalidate whole BTB (fence.i, context change)
ready  out  1  sweep complete, predictions and updates active

Behaviour:
- index = pc[INDEX_BITS+1:2]; tag = pc[XLEN-1:INDEX_BITS+2]. Each entry holds valid, tag, target, ctr[1:0], is_br.
- Reset: clk and reset are one clock, one synchronous active-low reset. While reset=0, the FSM is forced to BP_INIT with sweep_idx=0 and ready=0. The entry arrays themselves are not reset.
- BP_INIT: each cycle after reset is released, clear valid[sweep_idx] and increment sweep_idx. When sweep_idx==BTB_ENTRIES-1 has been cleared, move to BP_RUN. ready rises exactly BTB_ENTRIES cycles after the first cycle with reset=1.
- BP_RUN: ready=1. A flush_all=1 sampled at a clock edge moves the FSM to BP_INIT with sweep_idx=0 and ready=0 on the next cycle. A flush_all during BP_INIT restarts the sweep at 0.
- Lookup is combinational from if_pc:
  - pred_hit = ready & valid & tag match.
  - pred_taken = pred_hit & (!is_br | ctr[1]).
  - pred_target = pred_taken ? entry.target : if_pc+4, with 32-bit wrap.
  - With ready=0, all outputs read as not taken and pred_target = if_pc+4.
- Update applies on the clock edge when update_en & ready & !flush_all. Otherwise it is dropped silently.
  - Update hit (valid & tag match):
    - If update_is_branch: ctr saturates, incrementing when taken and decrementing when not taken (00↔11 bounds).
    - If update_taken: write target.
    - Always write is_br.
  - Update miss with update_taken=1: allocate (replace any occupant). Set valid=1, write tag and target, is_br=update_is_branch, ctr=2'b10 (weakly taken).
  - Update miss with update_taken=0: no state change.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents. The new contents are visible next cycle. There is no internal bypass.
- Update and flush_all in the same cycle: flush wins and the update is discarded.
- Reset mid-sweep or mid-run: the FSM returns to BP_INIT and the sweep restarts from 0.

Decomposition:
- riscv_pkg additions:
  - bp_state_e {BP_INIT, BP_RUN}
  - btb_entry_t struct {valid, tag, target, ctr, is_br}
  - constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
- One sub-module is natural: sat_ctr2, a combinational 2-bit saturating next-value function (ctr, taken → ctr_next), so it can be reused by a future gshare/BHT.
- Arrays live in branch_pred_unit as register arrays, written to be SRAM-inferable (no reset on the arrays).

Test Plan:
- Release reset at cycle 0 with BTB_ENTRIES=64 → ready=0 for cycles 0-63 and 1 at cycle 64. During the sweep, if_pc=0x100 gives pred_hit=0, pred_target=0x104.
- Update pc=0x100, taken=1, target=0x80, is_branch=1 → next cycle, if_pc=0x100 gives hit=1, taken=1, target=0x80, ctr=10.
- Training on the 0x100 entry: two not-taken updates → ctr=00, pred_taken=0, pred_target=0x104. Then four taken updates → ctr saturates at 11 and stays there.
- Aliasing: entry at 0x100, then lookup 0x200 (same index 0) → hit=0. A taken update at 0x200 (target 0x300) replaces the entry, and 0x100 now misses.
- Jump entry: pc=0x40, is_branch=0, target 0x400 → always taken. A later not-taken update leaves ctr unchanged and prediction stays taken.
- flush_all asserted while valid entries exist → ready=0 for 64 cycles and all lookups miss afterward. An update issued during the sweep, and one issued in the same cycle as flush_all, are both dropped. A lookup in the same cycle as an update to the same PC returns the old value.
